// File: rtl/ram2p_pkg.sv
// Shared constants for the ram2p_dual true dual-port RAM.
// Build option: RAM2P_OUTREG_EN adds a second output register stage per port.
package ram2p_pkg;

  localparam int RAM2P_DEPTH = 256;
  localparam int RAM2P_AWID  = 8;
  localparam int RAM2P_DWID  = 16;

  // Cycles from address sampled to data visible on the output port.
`ifdef RAM2P_OUTREG_EN
  localparam int RAM2P_RD_LAT = 2;
`else
  localparam int RAM2P_RD_LAT = 1;
`endif

endpackage

// File: rtl/ram2p_oreg.sv
// Per-port read-data output pipeline. The first stage always exists. Defining
// RAM2P_OUTREG_EN adds a second stage. Every stage clears on synchronous reset.
module ram2p_oreg
  import ram2p_pkg::*;
#(
  parameter int DWID = RAM2P_DWID
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DWID-1:0] i_d,
  output logic [DWID-1:0] o_q
);

  logic [DWID-1:0] s1_d, s1_q;

  // First stage captures the raw array read.
  always_comb s1_d = i_d;

  // First stage register, cleared while reset is held.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values no matter what order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!rst_n) s1_q <= '0;
    else        s1_q <= s1_d;
  end

`ifdef RAM2P_OUTREG_EN
  logic [DWID-1:0] s2_d, s2_q;

  // Second stage re-times the first stage output.
  always_comb s2_d = s1_q;

  // Second stage register, also cleared while reset is held.
  always_ff @(posedge clk) begin
    if (!rst_n) s2_q <= '0;
    else        s2_q <= s2_d;
  end

  assign o_q = s2_q;
`else
  assign o_q = s1_q;
`endif

endmodule

// File: rtl/ram2p_dual.sv
// True dual-port synchronous RAM with independent read/write ports A and B on
// one clock. Reads are read-first on both ports. When both ports write the same
// word in one cycle, port A wins.
// Build option: RAM2P_OUTREG_EN adds one more output stage, so reads take 2 cycles.
module ram2p_dual
  import ram2p_pkg::*;
#(
  parameter int DEPTH = RAM2P_DEPTH,
  parameter int AWID  = RAM2P_AWID,
  parameter int DWID  = RAM2P_DWID
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wea,
  input  logic [AWID-1:0] i_addra,
  input  logic [DWID-1:0] i_data,
  output logic [DWID-1:0] o_data,
  input  logic            i_web,
  input  logic [AWID-1:0] i_addrb,
  input  logic [DWID-1:0] i_datb,
  output logic [DWID-1:0] o_datb
);

  // The array is addressed with the full address width, so the depth must match it.
  if (DEPTH != 2 ** AWID) begin : g_depth_check
    $error("ram2p_dual: DEPTH (%0d) must equal 2**AWID (%0d)", DEPTH, 2 ** AWID);
  end

  logic [DWID-1:0] mem [DEPTH];

  logic            wr_a_en, wr_b_en;
  logic [DWID-1:0] rd_a_data, rd_b_data;

  // Gate writes with reset and read both ports from the array combinationally.
  always_comb begin
    wr_a_en   = i_wea & rst_n;
    wr_b_en   = i_web & rst_n;
    rd_a_data = mem[i_addra];
    rd_b_data = mem[i_addrb];
  end

  // Array write. Port B is written first, so port A wins on a same-address collision.
  // NOTE: the array has no reset. Its contents survive reset, and leaving it
  // unreset lets the array map onto block RAM. The non-blocking update also
  // makes a read in the same cycle return the old word (read-first).
  always_ff @(posedge clk) begin
    if (wr_b_en) mem[i_addrb] <= i_datb;
    if (wr_a_en) mem[i_addra] <= i_data;
  end

  ram2p_oreg #(.DWID(DWID)) u_oreg_a (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rd_a_data),
    .o_q   (o_data)
  );

  ram2p_oreg #(.DWID(DWID)) u_oreg_b (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rd_b_data),
    .o_q   (o_datb)
  );

endmodule

// File: tb/tb_ram2p_dual.sv
// Self-checking bench for ram2p_dual. A reference memory supplies read-first
// expected data. Each expectation is queued with the cycle it falls due and is
// compared when the DUT output for that cycle is available.
module tb_ram2p_dual;
  import ram2p_pkg::*;

  localparam int AW  = RAM2P_AWID;
  localparam int DW  = RAM2P_DWID;
  localparam int LAT = RAM2P_RD_LAT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_wea, i_web;
  logic [AW-1:0] i_addra, i_addrb;
  logic [DW-1:0] i_data, i_datb;
  logic [DW-1:0] o_data, o_datb;

  ram2p_dual dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wea   (i_wea),
    .i_addra (i_addra),
    .i_data  (i_data),
    .o_data  (o_data),
    .i_web   (i_web),
    .i_addrb (i_addrb),
    .i_datb  (i_datb),
    .o_datb  (o_datb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          port;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [2 ** AW];
  int            cyc      = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%04h expected 0x%04h", tag, cyc, got, exp);
    end
  endtask

  // Drive one cycle. chk_a/chk_b queue an expectation for that port.
  task automatic cycle(input bit rst, input bit wea, input logic [AW-1:0] aa,
                       input logic [DW-1:0] da, input bit chk_a, input bit web,
                       input logic [AW-1:0] ab, input logic [DW-1:0] db,
                       input bit chk_b);
    exp_t e;
    rst_n   = rst;
    i_wea   = wea;
    i_addra = aa;
    i_data  = da;
    i_web   = web;
    i_addrb = ab;
    i_datb  = db;
    if (chk_a) begin
      e.due = cyc + (rst ? LAT : 1); e.port = 1'b0; e.exp = rst ? model[aa] : '0;
      sb.push_back(e);
    end
    if (chk_b) begin
      e.due = cyc + (rst ? LAT : 1); e.port = 1'b1; e.exp = rst ? model[ab] : '0;
      sb.push_back(e);
    end
    if (rst) begin
      if (web) model[ab] = db;
      if (wea) model[aa] = da;
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due == cyc) begin
        if (sb[k].port) check("o_datb", o_datb, sb[k].exp);
        else            check("o_data", o_data, sb[k].exp);
        sb.delete(k);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; i_wea = 1'b0; i_web = 1'b0;
    i_addra = '0; i_addrb = '0; i_data = '0; i_datb = '0;
    #2;

    // Reset from power-up: both outputs must be zero.
    repeat (2) cycle(0, 0, 0, 0, 1, 0, 0, 0, 1);

    // Fill through port A with data equal to the address.
    for (int i = 0; i < 2 ** AW; i++) cycle(1, 1, AW'(i), DW'(i), 0, 0, 0, 0, 0);

    // Read the whole array back through port B.
    for (int i = 0; i < 2 ** AW; i++) cycle(1, 0, 0, 0, 0, 0, AW'(i), 0, 1);

    // Reset again, with writes to address 7 that must be suppressed.
    repeat (2) cycle(0, 1, 7, 16'hBEEF, 1, 1, 7, 16'hDEAD, 1);
    cycle(1, 0, 5, 0, 1, 0, 7, 0, 1);

    // Same-port read during write: old data first, new data on the next read.
    cycle(1, 1, 10, 16'hBEEF, 1, 0, 0, 0, 0);
    cycle(1, 0, 10, 0, 1, 0, 0, 0, 0);

    // Port A writes while port B reads the same address.
    cycle(1, 1, 20, 16'h1234, 0, 0, 20, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 20, 0, 1);

    // Both ports write one address: both outputs show old data, then A's data.
    cycle(1, 1, 30, 16'hAAAA, 1, 1, 30, 16'h5555, 1);
    cycle(1, 0, 30, 0, 1, 0, 30, 0, 1);

    // Top address written through port B, read through A. Address 0 is untouched.
    cycle(1, 0, 0, 0, 0, 1, 8'hFF, 16'hFFFF, 0);
    cycle(1, 0, 8'hFF, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0, 0, 0);

    // Drain outstanding expectations within a bounded number of cycles.
    for (int n = 0; n < LAT + 4 && sb.size() != 0; n++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("drain", DW'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
